cache_const_mul_pipe: RTL and testbench
=======================================

# cache_const_mul_pipe

Parametrised, pipelined constant multiplier for the cache/PE datapath. It computes `in1 * MUL_K` with a configurable constant, input/output widths and pipeline depth. A valid/ready handshake lets the block stall under back-pressure without losing or duplicating samples. It replaces the fixed ×10, fixed-latency, handshake-free multipliers in `pe_array/cachelib`, and is placed wherever an index or address is scaled by a compile-time stride.

## Interface
Parameters:
- `IN_W`, 16: width of the unsigned multiplicand.
- `MUL_K`, 10: unsigned constant multiplier, 1..65535.
- `OUT_W`, 20: output width. Any value ≥ 1; need not hold the full product.
- `STAGES`, 2: pipeline register stages between input and output, 1..4.

Ports:
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `in_vld` input 1: `in1` carries a valid sample.
- `in_rdy` output 1: the block accepts a sample this cycle.
- `in1` input IN_W: unsigned multiplicand.
- `out_vld` output 1: `out1` / `out_ovf` hold a valid result.
- `out_rdy` input 1: downstream accepts the result.
- `out1` output OUT_W: product, truncated or saturated (see Configuration).
- `out_ovf` output 1: full product exceeds 2^OUT_W−1. Valid with `out_vld`.

## Operation
- **Full product width.** `P_W = IN_W + clog2(MUL_K+1)`. The product is exact at P_W bits inside the block. Only the final stage reduces it to OUT_W.
- **Multiplication method.** Multiplication uses shift-add only, no `*` operator. Implement it as the canonical-signed-digit decomposition of MUL_K, computed at elaboration.
  - Partial sums are distributed over the STAGES registers.
  - Stage 1 always registers the input operand or first-level partial sums.
  - The last stage holds the final P_W-bit sum, reduced to OUT_W.
- **Stage valid bits.** Each stage s has a valid bit `v[s]`. A stage advances when `!v[s] || adv[s+1]`; the last stage advances when `!v[last] || out_rdy`.
  - The ready chain is combinational.
  - Bubbles collapse: an empty stage always accepts a sample, even while downstream is stalled.
- **Input handshake.** `in_rdy` equals the advance condition of stage 1. A transfer occurs when `in_vld && in_rdy`.
- **Output handshake.** `out_vld = v[last]`. A transfer occurs when `out_vld && out_rdy`.
- **Stability under stall.** While `out_vld && !out_rdy`, `out1`, `out_ovf` and `out_vld` hold stable.
- **Ordering.** Results leave in acceptance order. No sample is dropped or duplicated.
- **Simultaneous events.** With a full pipe and `out_rdy=1`, one sample leaves and one enters in the same cycle. Throughput is 1/cycle.
- **Overflow flag.** `out_ovf = |P[P_W-1:OUT_W]`. It is tied to 0 when OUT_W ≥ P_W.
- **Edge-case constants.**
  - MUL_K = 1 degenerates to a registered pass-through of STAGES cycles.
  - MUL_K a power of two yields a pure shift.
- **Reset.** Reset asserted at any time, including mid-stall, clears every stage asynchronously.
  - All `v[s]` = 0, all data registers = 0.
  - Resulting outputs: `out_vld=0`, `out1=0`, `out_ovf=0`, `in_rdy=1`.
  - In-flight samples are discarded.

## Timing
- **Latency.** Exactly STAGES cycles from an accepted input edge to `out_vld` high, given `out_rdy=1` throughout.
- **Stall.** Each cycle of `out_rdy=0` with a full pipe adds one cycle of latency to every sample in flight.
- **Refill.** After reset deassertion, the first sample may be accepted on the first rising edge. `in_rdy` is 1 while any stage is empty.
- **Critical path.** No combinational path from `in1` to `out1`. The only combinational input-to-output path is `out_rdy` → `in_rdy`.

## Configuration
- **`CONST_MUL_SAT_EN` defined.** When `out_ovf=1`, `out1` = 2^OUT_W−1 (all ones). Otherwise `out1` = P.
- **`CONST_MUL_SAT_EN` undefined.** `out1 = P[OUT_W-1:0]`, i.e. modulo 2^OUT_W. `out_ovf` is still reported.
- **Applies in both builds:** the macro affects only final-stage reduction logic. Latency and handshake are identical either way.

## Test plan
- **Defaults, back-to-back.** Default params, `out_rdy=1`, inputs 0, 1, 0x1234, 0xFFFF on consecutive cycles → after 2 cycles, outputs 0x00000, 0x0000A, 0x0B608, 0x9FFF6 on consecutive cycles, `out_ovf=0`.
- **Back-pressure.** Default params, 4 samples while `out_rdy=0`. After 2 accepted, `in_rdy` falls. Then raise `out_rdy`: all 4 products emerge in order with no gaps. `out1` stays stable while stalled.
- **Bubble collapse.** Default params, STAGES=3, a single sample then `out_rdy=0`. `in_rdy` stays 1 until 3 samples are held, then drops to 0.
- **Overflow, saturating.** OUT_W=18, `CONST_MUL_SAT_EN` defined, in 0xFFFF → `out1`=0x3FFFF, `out_ovf`=1. In 0x6666 (×10 = 0x3FFFC) → `out1`=0x3FFFC, `out_ovf`=0.
- **Overflow, wrapping.** OUT_W=18, macro undefined, in 0xFFFF → `out1`=0x1FFF6, `out_ovf`=1.
- **Reset mid-stall.** Full pipe, `out_rdy=0`, pulse `rst` low mid-cycle → `out_vld`, `out1`, `out_ovf` go 0 immediately and `in_rdy`=1. Old samples never appear after release. MUL_K=1 and MUL_K=64 sweeps match the reference model `(in1*MUL_K)` reduced per the active Configuration build.

Source files
------------

// File: rtl/cache_const_mul_pipe.sv
// cache_const_mul_pipe
//   Pipelined multiply of an unsigned operand by a compile-time constant,
//   out1 = in1 * MUL_K. The constant is decomposed at elaboration into
//   canonical-signed-digit terms, and the shift-add terms are spread over
//   STAGES register stages. A valid/ready handshake on both sides supports
//   back-pressure, and empty stages collapse.
//
// Parameters
//   IN_W    multiplicand width
//   MUL_K   constant multiplier, 1..65535
//   OUT_W   result width (may be narrower than the full product)
//   STAGES  register stages between input and output, 1..4
//
// Ports
//   clk      clock, rising edge
//   rst      asynchronous active-low reset; clears every stage
//   in_vld   in1 carries a sample
//   in_rdy   sample is accepted this cycle (in_vld && in_rdy)
//   in1      unsigned multiplicand
//   out_vld  out1/out_ovf hold a result
//   out_rdy  downstream takes the result (out_vld && out_rdy)
//   out1     product reduced to OUT_W bits
//   out_ovf  full product does not fit in OUT_W bits
//
// Build option
//   CONST_MUL_SAT_EN  when defined, an overflowing product saturates out1 to
//                     all ones; otherwise out1 wraps modulo 2^OUT_W.

module cache_const_mul_pipe #(
  parameter int unsigned IN_W   = 16,
  parameter int unsigned MUL_K  = 10,
  parameter int unsigned OUT_W  = 20,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [IN_W-1:0]  in1,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [OUT_W-1:0] out1,
  output logic             out_ovf
);

  localparam int unsigned P_W   = IN_W + $clog2(MUL_K + 1);
  localparam int unsigned CSD_W = 18;
  localparam int unsigned LAST  = STAGES - 1;

  // Canonical-signed-digit recoding: returns {negative digits, positive digits}.
  function automatic logic [2*CSD_W-1:0] csd_digits(input int unsigned k);
    int unsigned       r;
    logic [CSD_W-1:0]  pos;
    logic [CSD_W-1:0]  neg;
    r   = k;
    pos = '0;
    neg = '0;
    for (int unsigned i = 0; i < CSD_W; i++) begin
      if ((r & 32'd3) == 32'd1) begin
        pos[i] = 1'b1;
        r      = r - 32'd1;
      end else if ((r & 32'd3) == 32'd3) begin
        neg[i] = 1'b1;
        r      = r + 32'd1;
      end
      r = r >> 1;
    end
    return {neg, pos};
  endfunction

  function automatic int unsigned count_terms(input logic [CSD_W-1:0] m);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < CSD_W; i++) begin
      if (m[i]) n = n + 1;
    end
    return n;
  endfunction

  localparam logic [2*CSD_W-1:0] CSD     = csd_digits(MUL_K);
  localparam logic [CSD_W-1:0]   CSD_POS = CSD[CSD_W-1:0];
  localparam logic [CSD_W-1:0]   CSD_NEG = CSD[2*CSD_W-1:CSD_W];
  localparam int unsigned        NT      = count_terms(CSD_POS | CSD_NEG);

  // Adds the nonzero CSD terms with ordinal index in [lo, hi) to acc.
  // Arithmetic is modulo 2^P_W: intermediate sums may go transiently
  // negative, but the final sum equals the true product, which fits in P_W.
  function automatic logic [P_W-1:0] add_terms(
    input logic [P_W-1:0]  acc,
    input logic [IN_W-1:0] x,
    input int unsigned     lo,
    input int unsigned     hi
  );
    logic [P_W-1:0] xe;
    logic [P_W-1:0] r;
    int unsigned    n;
    xe = P_W'(x);
    r  = acc;
    n  = 0;
    for (int unsigned i = 0; i < CSD_W; i++) begin
      if (CSD_POS[i] || CSD_NEG[i]) begin
        if (n >= lo && n < hi) begin
          if (CSD_POS[i]) r = r + (xe << i);
          else            r = r - (xe << i);
        end
        n = n + 1;
      end
    end
    return r;
  endfunction

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] v_up;
  logic [STAGES-1:0] adv;

  logic [P_W-1:0]    p_fin;
  logic [OUT_W-1:0]  red_out;
  logic              red_ovf;
  logic [OUT_W-1:0]  out_q;
  logic              ovf_q;

  // Ready chain: a stage advances when it is empty or its successor
  // advances; walking from the output back makes this a running OR.
  always_comb begin
    logic ok;
    adv  = '0;
    v_up = '0;
    ok   = out_rdy;
    for (int unsigned i = 0; i < STAGES; i++) begin
      ok            = ok || !v[LAST - i];
      adv[LAST - i] = ok;
    end
    v_up[0] = in_vld;
    for (int unsigned i = 1; i < STAGES; i++) begin
      v_up[i] = v[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) v <= '0;
    else      v <= (v & ~adv) | (v_up & adv);
  end

  generate
    if (STAGES == 1) begin : g_one
      always_comb p_fin = add_terms('0, in1, 0, NT);
    end else begin : g_mid
      logic [IN_W-1:0] x_q   [STAGES-1];
      logic [P_W-1:0]  acc_q [STAGES-1];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int unsigned s = 0; s < STAGES - 1; s++) begin
            x_q[s]   <= '0;
            acc_q[s] <= '0;
          end
        end else begin
          if (adv[0] && in_vld) begin
            x_q[0]   <= in1;
            acc_q[0] <= add_terms('0, in1, 0, NT / STAGES);
          end
          for (int unsigned s = 1; s < STAGES - 1; s++) begin
            if (adv[s] && v[s-1]) begin
              x_q[s]   <= x_q[s-1];
              acc_q[s] <= add_terms(acc_q[s-1], x_q[s-1],
                                    (s * NT) / STAGES, ((s + 1) * NT) / STAGES);
            end
          end
        end
      end

      always_comb p_fin = add_terms(acc_q[STAGES-2], x_q[STAGES-2],
                                    (LAST * NT) / STAGES, NT);
    end
  endgenerate

  generate
    if (OUT_W < P_W) begin : g_narrow
      always_comb begin
        red_ovf = |p_fin[P_W-1:OUT_W];
`ifdef CONST_MUL_SAT_EN
        red_out = red_ovf ? '1 : p_fin[OUT_W-1:0];
`else
        red_out = p_fin[OUT_W-1:0];
`endif
      end
    end else begin : g_wide
      always_comb begin
        red_ovf = 1'b0;
        red_out = OUT_W'(p_fin);
      end
    end
  endgenerate

  // Last stage holds the already-reduced result so out1 is a plain register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q <= '0;
      ovf_q <= 1'b0;
    end else if (adv[LAST] && v_up[LAST]) begin
      out_q <= red_out;
      ovf_q <= red_ovf;
    end
  end

  always_comb begin
    in_rdy  = adv[0];
    out_vld = v[LAST];
    out1    = out_q;
    out_ovf = ovf_q;
  end

endmodule

// File: tb/tb_cache_const_mul_pipe.sv
module tb_cache_const_mul_pipe;

  localparam int NI = 6;
  localparam int unsigned PK [NI] = '{10, 10, 10, 1, 64, 27};
  localparam int unsigned PS [NI] = '{2, 3, 2, 1, 4, 4};
  localparam int unsigned PO [NI] = '{20, 20, 18, 20, 20, 24};

  logic        clk;
  logic        rst;
  logic        in_vld;
  logic        out_rdy;
  logic [15:0] in1;

  logic        rdy_w [NI];
  logic        vld_w [NI];
  logic        ovf_w [NI];
  logic [31:0] ow    [NI];

  logic [19:0] o0, o1, o3, o4;
  logic [17:0] o2;
  logic [23:0] o5;

  assign ow[0] = 32'(o0);
  assign ow[1] = 32'(o1);
  assign ow[2] = 32'(o2);
  assign ow[3] = 32'(o3);
  assign ow[4] = 32'(o4);
  assign ow[5] = 32'(o5);

  cache_const_mul_pipe #(.IN_W(16), .MUL_K(10), .OUT_W(20), .STAGES(2)) u0 (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(rdy_w[0]), .in1(in1),
    .out_vld(vld_w[0]), .out_rdy(out_rdy), .out1(o0), .out_ovf(ovf_w[0]));
  cache_const_mul_pipe #(.IN_W(16), .MUL_K(10), .OUT_W(20), .STAGES(3)) u1 (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(rdy_w[1]), .in1(in1),
    .out_vld(vld_w[1]), .out_rdy(out_rdy), .out1(o1), .out_ovf(ovf_w[1]));
  cache_const_mul_pipe #(.IN_W(16), .MUL_K(10), .OUT_W(18), .STAGES(2)) u2 (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(rdy_w[2]), .in1(in1),
    .out_vld(vld_w[2]), .out_rdy(out_rdy), .out1(o2), .out_ovf(ovf_w[2]));
  cache_const_mul_pipe #(.IN_W(16), .MUL_K(1), .OUT_W(20), .STAGES(1)) u3 (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(rdy_w[3]), .in1(in1),
    .out_vld(vld_w[3]), .out_rdy(out_rdy), .out1(o3), .out_ovf(ovf_w[3]));
  cache_const_mul_pipe #(.IN_W(16), .MUL_K(64), .OUT_W(20), .STAGES(4)) u4 (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(rdy_w[4]), .in1(in1),
    .out_vld(vld_w[4]), .out_rdy(out_rdy), .out1(o4), .out_ovf(ovf_w[4]));
  cache_const_mul_pipe #(.IN_W(16), .MUL_K(27), .OUT_W(24), .STAGES(4)) u5 (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(rdy_w[5]), .in1(in1),
    .out_vld(vld_w[5]), .out_rdy(out_rdy), .out1(o5), .out_ovf(ovf_w[5]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int nvec;
  int nmis;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s[u%0d]: got 0x%0h, want 0x%0h at %0t", nm, idx, act, exp, $time);
    end
  endtask

  // Reference result: {overflow, out1} for x*k reduced to ow bits.
  function automatic logic [32:0] ref_res(input int unsigned x, input int unsigned k,
                                          input int unsigned owd);
    logic [63:0] p;
    logic [63:0] mx;
    logic        ov;
    logic [31:0] r;
    p  = 64'(x) * 64'(k);
    mx = (64'd1 << owd) - 64'd1;
    ov = p > mx;
`ifdef CONST_MUL_SAT_EN
    r = ov ? 32'(mx) : 32'(p);
`else
    r = 32'(p & mx);
`endif
    return {ov, r};
  endfunction

  // Model: per instance, a FIFO of accepted samples with their accept edge.
  // A sample is visible once it has passed STAGES registers and everything
  // ahead of it has left; the block is ready while it holds fewer than
  // STAGES samples or the output is being drained.
  int unsigned ecnt;
  int unsigned bv [NI][8];
  int unsigned ba [NI][8];
  int unsigned hd [NI];
  int unsigned cn [NI];

  initial begin
    ecnt = 0;
    for (int i = 0; i < NI; i++) begin hd[i] = 0; cn[i] = 0; end
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        ecnt = 0;
        for (int i = 0; i < NI; i++) begin hd[i] = 0; cn[i] = 0; end
      end else begin
        for (int i = 0; i < NI; i++) begin
          logic dep;
          logic acc;
          dep = (cn[i] > 0) && (ecnt >= ba[i][hd[i]] + PS[i] - 1) && out_rdy;
          acc = in_vld && ((cn[i] < PS[i]) || out_rdy);
          if (dep) begin
            hd[i] = (hd[i] + 1) % 8;
            cn[i] = cn[i] - 1;
          end
          if (acc) begin
            bv[i][(hd[i] + cn[i]) % 8] = 32'(in1);
            ba[i][(hd[i] + cn[i]) % 8] = ecnt + 1;
            cn[i] = cn[i] + 1;
          end
        end
        ecnt = ecnt + 1;
      end
    end
  end

  // Compare process: every cycle out of reset, all instances.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int i = 0; i < NI; i++) begin
          logic        erdy;
          logic        ev;
          logic [32:0] r;
          erdy = (cn[i] < PS[i]) || out_rdy;
          ev   = (cn[i] > 0) && (ecnt >= ba[i][hd[i]] + PS[i] - 1);
          chk("in_rdy", i, 32'(rdy_w[i]), 32'(erdy));
          chk("out_vld", i, 32'(vld_w[i]), 32'(ev));
          if (ev) begin
            r = ref_res(bv[i][hd[i]], PK[i], PO[i]);
            chk("out1", i, ow[i], r[31:0]);
            chk("out_ovf", i, 32'(ovf_w[i]), 32'(r[32]));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [15:0] tbl [12];

  initial begin
    nvec = 0; nmis = 0;
    tbl = '{16'h0000, 16'h0001, 16'hFFFF, 16'h8000, 16'h6666, 16'h6667,
            16'h1234, 16'h0F0F, 16'hA5A5, 16'h199A, 16'h4000, 16'h7FFF};
    rst = 1'b0; in_vld = 1'b0; in1 = '0; out_rdy = 1'b1;

    repeat (3) @(posedge clk);
    #2;
    chk("rst_vld", 0, 32'(vld_w[0]), 0);
    chk("rst_out1", 0, ow[0], 0);
    chk("rst_ovf", 0, 32'(ovf_w[0]), 0);
    chk("rst_rdy", 0, 32'(rdy_w[0]), 1);

    // Back-to-back with out_rdy=1
    @(posedge clk); #1 rst = 1'b1; in_vld = 1'b1; in1 = 16'h0000;
    @(posedge clk); #1 in1 = 16'h0001;
    @(posedge clk); #1 in1 = 16'h1234;
    @(negedge clk);
    chk("b2b_0", 0, ow[0], 32'h00000);
    chk("b2b_0_vld", 0, 32'(vld_w[0]), 1);
    @(posedge clk); #1 in1 = 16'hFFFF;
    @(negedge clk); chk("b2b_1", 0, ow[0], 32'h0000A);
    @(posedge clk); #1 in_vld = 1'b0;
    @(negedge clk); chk("b2b_2", 0, ow[0], 32'h0B608);
    @(negedge clk);
    chk("b2b_3", 0, ow[0], 32'h9FFF6);
    chk("b2b_3_ovf", 0, 32'(ovf_w[0]), 0);
`ifdef CONST_MUL_SAT_EN
    chk("ovf18_ffff", 2, ow[2], 32'h3FFFF);
`else
    chk("ovf18_ffff", 2, ow[2], 32'h1FFF6);
`endif
    chk("ovf18_ffff_flag", 2, 32'(ovf_w[2]), 1);
    repeat (4) @(posedge clk);
    #1;

    // Back-pressure
    out_rdy = 1'b0; in_vld = 1'b1; in1 = 16'h0011;
    @(posedge clk); #1 in1 = 16'h0022;
    @(posedge clk); #1 in1 = 16'h0033;
    @(negedge clk);
    chk("bp_rdy_low", 0, 32'(rdy_w[0]), 0);
    chk("bp_head", 0, ow[0], 32'h000AA);
    repeat (2) @(posedge clk);
    @(negedge clk); chk("bp_hold", 0, ow[0], 32'h000AA);
    @(posedge clk); #1 out_rdy = 1'b1;
    @(negedge clk); chk("bp_rdy_up", 0, 32'(rdy_w[0]), 1);
    @(posedge clk); #1 in1 = 16'h0044;
    @(posedge clk); #1 in_vld = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    // Bubble collapse on the 3-stage instance
    in_vld = 1'b1; in1 = 16'h0005;
    @(posedge clk); #1 out_rdy = 1'b0; in_vld = 1'b0;
    repeat (3) @(posedge clk);
    #1 in_vld = 1'b1; in1 = 16'h0006;
    @(negedge clk); chk("bub_1held", 1, 32'(rdy_w[1]), 1);
    @(posedge clk); #1 in1 = 16'h0007;
    @(negedge clk); chk("bub_2held", 1, 32'(rdy_w[1]), 1);
    @(posedge clk); #1;
    @(negedge clk); chk("bub_3held", 1, 32'(rdy_w[1]), 0);
    @(posedge clk); #1 out_rdy = 1'b1; in_vld = 1'b0;
    repeat (8) @(posedge clk);
    #1;

    // Largest in-range product for OUT_W=18
    in_vld = 1'b1; in1 = 16'h6666;
    @(posedge clk); #1 in_vld = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("ovf18_6666", 2, ow[2], 32'h3FFFC);
    chk("ovf18_6666_flag", 2, 32'(ovf_w[2]), 0);
    chk("k10_6666", 0, ow[0], 32'h3FFFC);
    repeat (4) @(posedge clk);
    #1;

    // Mixed sweep with irregular valid and ready patterns
    for (int j = 0; j < 36; j++) begin
      in_vld  = (j % 5) != 4;
      in1     = tbl[j % 12];
      out_rdy = (j % 4) != 3;
      @(posedge clk); #1;
    end
    out_rdy = 1'b1; in_vld = 1'b0;
    repeat (8) @(posedge clk);
    #1;

    // Reset in the middle of a stall with all pipes full
    out_rdy = 1'b0; in_vld = 1'b1; in1 = 16'hBEEF;
    repeat (6) @(posedge clk);
    #2 chk("pre_rst_vld", 0, 32'(vld_w[0]), 1);
    #1 rst = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("mid_rst_vld", i, 32'(vld_w[i]), 0);
      chk("mid_rst_out1", i, ow[i], 0);
      chk("mid_rst_ovf", i, 32'(ovf_w[i]), 0);
      chk("mid_rst_rdy", i, 32'(rdy_w[i]), 1);
    end
    @(posedge clk); #1 rst = 1'b1; out_rdy = 1'b1; in_vld = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    // Short sweep after reset recovery
    for (int j = 0; j < 12; j++) begin
      in_vld = 1'b1;
      in1    = tbl[11 - j];
      @(posedge clk); #1;
    end
    in_vld = 1'b0;
    repeat (8) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
